// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pkg
//  Brief    : SHA-256 constants, state encoding and round helper functions
//             shared by the stream core and its round datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] c_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] c_iv_256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] c_iv_224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_round
//  Brief    : One combinational SHA-256 compression round (a..h -> next a..h).
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_e,
    input  logic [31:0] i_f,
    input  logic [31:0] i_g,
    input  logic [31:0] i_h,
    input  logic [31:0] i_k,
    input  logic [31:0] i_w,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d,
    output logic [31:0] o_e,
    output logic [31:0] o_f,
    output logic [31:0] o_g,
    output logic [31:0] o_h
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    assign w_t1 = i_h + big_sigma1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;
    assign w_t2 = big_sigma0(i_a) + maj(i_a, i_b, i_c);

    assign o_a = w_t1 + w_t2;
    assign o_b = i_a;
    assign o_c = i_b;
    assign o_d = i_c;
    assign o_e = i_d + w_t1;
    assign o_f = i_e;
    assign o_g = i_f;
    assign o_h = i_g;

endmodule
`default_nettype wire

// File: rtl/sha256_stream_core.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_stream_core
//  Brief    : Multi-block SHA-256 engine, 1/2/4 rounds per cycle, chained H.
//             Optional SHA-224 support when SHA224_MODE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
`ifdef SHA224_MODE_EN
    input  logic         mode_224,
`endif
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest
);

    localparam int NUM_ITER = 64 / ROUNDS_PER_CYCLE;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
        $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t       r_state;
    logic [5:0]   r_cnt;
    logic [31:0]  r_w [0:15];
    logic [255:0] r_work;
    logic [255:0] r_h;
    logic         r_last;
    logic         r_blk_ready;
    logic         r_busy;
    logic         r_dv;
    logic [255:0] r_digest;
`ifdef SHA224_MODE_EN
    logic         r_mode;
`endif

    logic [31:0]  w_ext [0:15+ROUNDS_PER_CYCLE];
    logic [255:0] w_final;
    logic [255:0] w_h_new;
    logic [255:0] w_iv;
    logic [255:0] w_digest_next;

    // The window always holds W[t..t+15] for the first round of this cycle;
    // the extra R words are the ones that slide in at the next edge.
    always_comb begin
        for (int i = 0; i < 16 + ROUNDS_PER_CYCLE; i++) begin
            w_ext[i] = 32'h0;
        end
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_w[i];
        end
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_ext[16+j] = small_sigma1(w_ext[14+j]) + w_ext[9+j]
                        + small_sigma0(w_ext[1+j]) + w_ext[j];
        end
    end

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [255:0] w_in;
        logic [255:0] w_out;
        logic [5:0]   w_t;

        if (j == 0) begin : g_first
            assign w_in = r_work;
        end else begin : g_chain
            assign w_in = g_round[j-1].w_out;
        end

        assign w_t = r_cnt * 6'(ROUNDS_PER_CYCLE) + 6'(j);

        sha256_round u_round (
            .i_a (w_in[255:224]), .i_b (w_in[223:192]), .i_c (w_in[191:160]), .i_d (w_in[159:128]),
            .i_e (w_in[127:96]),  .i_f (w_in[95:64]),   .i_g (w_in[63:32]),   .i_h (w_in[31:0]),
            .i_k (c_k[w_t]),
            .i_w (w_ext[j]),
            .o_a (w_out[255:224]), .o_b (w_out[223:192]), .o_c (w_out[191:160]), .o_d (w_out[159:128]),
            .o_e (w_out[127:96]),  .o_f (w_out[95:64]),   .o_g (w_out[63:32]),   .o_h (w_out[31:0])
        );
    end

    assign w_final = g_round[ROUNDS_PER_CYCLE-1].w_out;

    for (genvar i = 0; i < 8; i++) begin : g_hadd
        assign w_h_new[255-32*i -: 32] = r_h[255-32*i -: 32] + r_work[255-32*i -: 32];
    end

`ifdef SHA224_MODE_EN
    assign w_iv          = mode_224 ? c_iv_224 : c_iv_256;
    assign w_digest_next = r_mode ? {w_h_new[255:32], 32'h0} : w_h_new;
`else
    assign w_iv          = c_iv_256;
    assign w_digest_next = w_h_new;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= 32'h0;
            end
            r_work      <= 256'h0;
            r_h         <= c_iv_256;
            r_last      <= 1'b0;
            r_blk_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_dv        <= 1'b0;
            r_digest    <= 256'h0;
`ifdef SHA224_MODE_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (blk_valid && r_blk_ready) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= blk_data[511-32*i -: 32];
                        end
                        r_last <= blk_last;
                        if (blk_first) begin
                            r_work <= w_iv;
                            r_h    <= w_iv;
`ifdef SHA224_MODE_EN
                            r_mode <= mode_224;
`endif
                        end else begin
                            r_work <= r_h;
                        end
                        r_cnt       <= 6'd0;
                        r_state     <= ROUND;
                        r_blk_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_blk_ready <= 1'b1;
                    end
                end
                ROUND: begin
                    r_work <= w_final;
                    for (int i = 0; i < 16; i++) begin
                        r_w[i] <= w_ext[i+ROUNDS_PER_CYCLE];
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(NUM_ITER - 1)) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
                    r_h <= w_h_new;
                    if (r_last) begin
                        r_digest <= w_digest_next;
                        r_dv     <= 1'b1;
                    end
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_blk_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign blk_ready    = r_blk_ready;
    assign busy         = r_busy;
    assign digest_valid = r_dv;
    assign digest       = r_digest;

endmodule
`default_nettype wire
